// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampled 8N1 UART receiver.
// Decodes LSB-first frames from an asynchronous pin and presents each byte
// through a one-entry valid/ready holding register, flagging framing errors
// (low stop bit) and overruns (byte completed while the holder is still full).
module uart_rx_os16 #(
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] TickReload = CntW'(CLK_DIV - 1);
  localparam logic [3:0] HalfSample = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LastSample = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t state_q, state_d;

  logic            sync1, rxs, rxs_prev;
  logic [CntW-1:0] tick_cnt;
  logic [3:0]      sample_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_q;

  logic tick;
  logic falling;
  logic start_det;
  logic sample_clr;
  logic shift_en;
  logic deliver;
  logic frame_err_d;

  assign tick    = (state_q != IDLE) && (tick_cnt == '0);
  assign falling = rxs_prev & ~rxs;
  assign rx_busy = (state_q != IDLE);

  // Two-flop synchronizer plus a previous-value flop; all reset to the idle
  // level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= uart_rx_in;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-cycle control strobes for the datapath.
  always_comb begin
    state_d     = state_q;
    start_det   = 1'b0;
    sample_clr  = 1'b0;
    shift_en    = 1'b0;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (falling) begin
          start_det = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (tick && (sample_cnt == HalfSample)) begin
          sample_clr = 1'b1;
          state_d    = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && (sample_cnt == LastSample)) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick && (sample_cnt == LastSample)) begin
          if (rxs) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Oversample tick divider: restarts on the start edge so ticks stay
  // phase-locked to the falling edge, free-runs while a frame is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (start_det) begin
      tick_cnt <= TickReload;
    end else if (state_q != IDLE) begin
      if (tick_cnt == '0) begin
        tick_cnt <= TickReload;
      end else begin
        tick_cnt <= tick_cnt - CntW'(1);
      end
    end
  end

  // Sample and bit counters; the sample counter wraps at 16 so it realigns
  // to mid-bit automatically after the half-bit start check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
    end else begin
      if (start_det || sample_clr) begin
        sample_cnt <= '0;
      end else if (tick) begin
        sample_cnt <= sample_cnt + 4'd1;
      end
      if (start_det || sample_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // LSB-first shift register: each mid-bit sample enters at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= {rxs, shift_q[7:1]};
    end
  end

  // Holding register and status pulses; a byte arriving while the holder
  // is full and not being drained is dropped and reported as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= frame_err_d;
      rx_overrun   <= deliver & rx_valid & ~rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: directed and randomized checks of the UART receiver,
// using a byte-level reference model (expected byte queue and flag counts).
module tb_uart_rx_os16;

  logic       clk;
  logic       rst_n;
  logic       uart_rx_in;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  // Observations collected by the monitor.
  logic [7:0] got_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe_cyc = -1;
  int ov_cyc = -1;
  int valid_rise_cyc = -1;
  int busy_rise_cyc = -1;
  int busy_fall_cyc = -1;
  logic valid_d = 1'b0;
  logic busy_d = 1'b0;

  // Reference model state for the randomized phase.
  logic [7:0] exp_q[$];
  int exp_fe = 0;

  uart_rx_os16 #(.CLK_DIV(27), .OVERSAMPLE(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_rx_in(uart_rx_in),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err),
    .rx_overrun(rx_overrun),
    .rx_busy(rx_busy)
  );

  // 50 MHz clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Free-running cycle count used to time-stamp events.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: record handshakes, flag pulses and the
  // first rising/falling edges of valid and busy since the last clear.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (rx_overrun) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    if (rx_valid && !valid_d && valid_rise_cyc < 0) valid_rise_cyc = cyc;
    if (rx_busy && !busy_d && busy_rise_cyc < 0) busy_rise_cyc = cyc;
    if (!rx_busy && busy_d && busy_fall_cyc < 0) busy_fall_cyc = cyc;
    valid_d = rx_valid;
    busy_d  = rx_busy;
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearMon();
    got_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    fe_cyc = -1;
    ov_cyc = -1;
    valid_rise_cyc = -1;
    busy_rise_cyc = -1;
    busy_fall_cyc = -1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one 8N1 frame starting now; the line is left at the stop level.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input int bit_clks);
    start_cyc = cyc;
    uart_rx_in = 1'b0;
    waitCycles(bit_clks);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = data[i];
      waitCycles(bit_clks);
    end
    uart_rx_in = stop_bit;
    waitCycles(bit_clks);
  endtask

  initial begin
    logic [7:0] d;
    int bc;
    int gap;
    logic good;
    int s1;

    rst_n = 1'b0;
    uart_rx_in = 1'b1;
    rx_ready = 1'b0;
    waitCycles(5);
    $display("[TB] reset values");
    checkOutput("reset_data", rx_data, 32'h00);
    checkOutput("reset_valid", rx_valid, 32'h0);
    checkOutput("reset_frame_err", rx_frame_err, 32'h0);
    checkOutput("reset_overrun", rx_overrun, 32'h0);
    checkOutput("reset_busy", rx_busy, 32'h0);
    rst_n = 1'b1;
    waitCycles(5);

    // Nominal byte with a ready consumer.
    $display("[TB] byte 0xA5 nominal");
    clearMon();
    rx_ready = 1'b1;
    applyStimulus(8'hA5, 1'b1, 432);
    waitCycles(10);
    checkOutput("a5_count", got_q.size(), 32'd1);
    checkOutput("a5_data", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hx, 32'hA5);
    checkOutput("a5_latency", valid_rise_cyc - start_cyc, 32'd4107);
    checkOutput("a5_busy_rise", busy_rise_cyc - start_cyc, 32'd3);
    checkOutput("a5_busy_fall", busy_fall_cyc - start_cyc, 32'd4107);
    checkOutput("a5_flags", fe_cnt + ov_cnt, 32'd0);
    checkOutput("a5_valid_cleared", rx_valid, 32'h0);

    // Short low glitch on an idle line.
    $display("[TB] start glitch");
    clearMon();
    start_cyc = cyc;
    uart_rx_in = 1'b0;
    waitCycles(100);
    uart_rx_in = 1'b1;
    waitCycles(300);
    checkOutput("glitch_busy_rise", busy_rise_cyc - start_cyc, 32'd3);
    checkOutput("glitch_busy_fall", busy_fall_cyc - start_cyc, 32'd219);
    checkOutput("glitch_no_valid", valid_rise_cyc, 32'hFFFFFFFF);
    checkOutput("glitch_no_frame_err", fe_cnt, 32'd0);

    // Low stop bit followed by a held break.
    $display("[TB] framing error and break");
    clearMon();
    applyStimulus(8'h3C, 1'b0, 432);
    waitCycles(2000);
    checkOutput("ferr_count", fe_cnt, 32'd1);
    checkOutput("ferr_time", fe_cyc - start_cyc, 32'd4107);
    checkOutput("ferr_no_valid", valid_rise_cyc, 32'hFFFFFFFF);
    checkOutput("ferr_no_overrun", ov_cnt, 32'd0);
    checkOutput("ferr_busy_in_break", rx_busy, 32'h1);
    uart_rx_in = 1'b1;
    waitCycles(10);
    checkOutput("ferr_busy_after_break", rx_busy, 32'h0);

    // Two back-to-back bytes with no consumer: second one overruns.
    $display("[TB] overrun");
    clearMon();
    rx_ready = 1'b0;
    applyStimulus(8'h11, 1'b1, 432);
    applyStimulus(8'h22, 1'b1, 432);
    waitCycles(10);
    checkOutput("ovr_data_kept", rx_data, 32'h11);
    checkOutput("ovr_valid_held", rx_valid, 32'h1);
    checkOutput("ovr_count", ov_cnt, 32'd1);
    checkOutput("ovr_time", ov_cyc - start_cyc, 32'd4107);
    checkOutput("ovr_no_frame_err", fe_cnt, 32'd0);
    rx_ready = 1'b1;
    waitCycles(1);
    rx_ready = 1'b0;
    checkOutput("ovr_drain", rx_valid, 32'h0);

    // Ready asserted exactly as the second byte lands: replace, no overrun.
    $display("[TB] ready coincident with delivery");
    clearMon();
    applyStimulus(8'h11, 1'b1, 432);
    fork
      applyStimulus(8'h22, 1'b1, 432);
      begin
        waitCycles(4106);
        rx_ready = 1'b1;
        waitCycles(1);
        rx_ready = 1'b0;
      end
    join
    waitCycles(10);
    checkOutput("coin_data", rx_data, 32'h22);
    checkOutput("coin_valid", rx_valid, 32'h1);
    checkOutput("coin_no_overrun", ov_cnt, 32'd0);
    checkOutput("coin_consumed_first",
                (got_q.size() == 1) ? 32'(got_q[0]) : 32'hx, 32'h11);

    // Reset in the middle of data bit 4 of 0x5A.
    $display("[TB] reset mid-frame");
    d = 8'h5A;
    uart_rx_in = 1'b0;
    waitCycles(432);
    for (int i = 0; i < 4; i++) begin
      uart_rx_in = d[i];
      waitCycles(432);
    end
    uart_rx_in = d[4];
    waitCycles(200);
    rst_n = 1'b0;
    uart_rx_in = 1'b1;
    waitCycles(3);
    checkOutput("midrst_data", rx_data, 32'h00);
    checkOutput("midrst_valid", rx_valid, 32'h0);
    checkOutput("midrst_busy", rx_busy, 32'h0);
    checkOutput("midrst_flags", {rx_frame_err, rx_overrun}, 32'h0);
    rst_n = 1'b1;
    waitCycles(20);
    checkOutput("postrst_busy", rx_busy, 32'h0);

    // 0xC3 at nominal, -4% and +4% bit periods.
    rx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bc = (k == 0) ? 432 : ((k == 1) ? 415 : 449);
      $display("[TB] byte 0xC3 at %0d clk/bit", bc);
      clearMon();
      applyStimulus(8'hC3, 1'b1, bc);
      waitCycles(20);
      checkOutput($sformatf("c3_%0d_count", bc), got_q.size(), 32'd1);
      checkOutput($sformatf("c3_%0d_data", bc),
                  (got_q.size() > 0) ? 32'(got_q[0]) : 32'hx, 32'hC3);
      checkOutput($sformatf("c3_%0d_flags", bc), fe_cnt + ov_cnt, 32'd0);
    end

    // Randomized frames against the byte-level model.
    $display("[TB] randomized frames");
    clearMon();
    exp_q.delete();
    exp_fe = 0;
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      bc = $urandom_range(418, 446);
      good = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 40);
      applyStimulus(d, good, bc);
      if (good) begin
        exp_q.push_back(d);
      end else begin
        exp_fe++;
        uart_rx_in = 1'b1;
        gap = gap + 20;
      end
      waitCycles(gap);
    end
    waitCycles(50);
    checkOutput("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      s1 = i;
      checkOutput($sformatf("rand_byte%0d", s1),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hx, 32'(exp_q[i]));
    end
    checkOutput("rand_frame_err", fe_cnt, exp_fe);
    checkOutput("rand_overrun", ov_cnt, 32'd0);
    checkOutput("rand_idle", rx_busy, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
